// File: rtl/pmd85_pkg.sv
// Shared definitions for the ROM pack loader.
//   IOCTL_IDX_ROMPACK : download index that targets the ROM pack
//   ROMPACK_AW        : ROM pack address width (32 KB)
//   loader_state_e    : loader FSM state encoding
package pmd85_pkg;

    localparam int IOCTL_IDX_ROMPACK = 1;
    localparam int ROMPACK_AW        = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_e;

endpackage

// File: rtl/ioctl_skid_buf.sv
// One-entry holding buffer for a downloaded byte and its address.
//   clk_sys, reset_n : clock, async active-low reset
//   push             : load push_addr/push_data, buffer becomes valid
//   pop              : buffered byte consumed this cycle
//   valid/addr/data  : buffer contents
// A push in the same cycle as a pop wins, so a byte can stream through
// every cycle without loss.
module ioctl_skid_buf #(
    parameter int AW = 15
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic          valid,
    output logic [AW-1:0] addr,
    output logic [7:0]    data
);

    logic          valid_q, valid_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (pop) begin
            valid_d = 1'b0;
        end
        if (push) begin
            valid_d = 1'b1;
            addr_d  = push_addr;
            data_d  = push_data;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign addr  = addr_q;
    assign data  = data_q;

endmodule

// File: rtl/rom_pack_loader.sv
// ROM pack loader: writes a downloaded image into the pack RAM while
// sharing the RAM port with core reads (core reads have priority).
//   ioctl_*   : download interface (window, index, byte strobe, addr, data,
//               back-pressure)
//   cpu_*     : core read request/address and one-cycle acknowledge
//   mem_*     : pack RAM address, write data, write enable
//   loaded, pack_size, overflow, busy : image status
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no image since reset; waiting for a matching download
// ST_RECV  | download window open; bytes captured and committed
// ST_FLUSH | window closed; draining the last buffered byte
// ST_DONE  | load finished; loaded reflects pack_size != 0
module rom_pack_loader
    import pmd85_pkg::*;
#(
    parameter int INDEX = IOCTL_IDX_ROMPACK,
    parameter int AW    = ROMPACK_AW
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ioctl_download,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_wr,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    output logic          ioctl_wait,
    input  logic          cpu_rd_req,
    input  logic [AW-1:0] cpu_addr,
    output logic          cpu_ack,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_din,
    output logic          mem_we,
    output logic          loaded,
    output logic [AW:0]   pack_size,
    output logic          overflow,
    output logic          busy
);

    loader_state_e state_q, state_d;
    logic          dl_q;
    logic          cpu_ack_q;
    logic          loaded_q, loaded_d;
    logic          overflow_q, overflow_d;
    logic [AW:0]   pack_size_q, pack_size_d;

    logic          buf_valid;
    logic [AW-1:0] buf_addr;
    logic [7:0]    buf_data;

    logic          dl_rise, dl_fall, start, in_xfer;
    logic          addr_ok, wr_rx, push, drop, commit;
    logic [AW:0]   commit_size;

    assign dl_rise = ioctl_download & ~dl_q;
    assign dl_fall = ~ioctl_download & dl_q;
    assign in_xfer = (state_q == ST_RECV) || (state_q == ST_FLUSH);
    assign start   = ((state_q == ST_IDLE) || (state_q == ST_DONE)) &&
                     dl_rise && (ioctl_index == 8'(INDEX));

    assign addr_ok = (ioctl_addr >> AW) == 25'd0;
    assign wr_rx   = (state_q == ST_RECV) && ioctl_wr;
    assign commit  = in_xfer && buf_valid && !cpu_rd_req;
    // Capture is allowed into an empty buffer or one being drained now.
    assign push    = wr_rx && addr_ok && (!buf_valid || commit);
    assign drop    = wr_rx && !push;

    assign commit_size = {1'b0, buf_addr} + (AW+1)'(1);

    ioctl_skid_buf #(.AW(AW)) u_buf (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .push      (push),
        .push_addr (ioctl_addr[AW-1:0]),
        .push_data (ioctl_dout),
        .pop       (commit),
        .valid     (buf_valid),
        .addr      (buf_addr),
        .data      (buf_data)
    );

    always_comb begin
        state_d     = state_q;
        loaded_d    = loaded_q;
        overflow_d  = overflow_q;
        pack_size_d = pack_size_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_RECV;
                    loaded_d    = 1'b0;
                    overflow_d  = 1'b0;
                    pack_size_d = '0;
                end
            end
            ST_RECV: begin
                if (dl_fall) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!buf_valid) begin
                    state_d  = ST_DONE;
                    loaded_d = (pack_size_q != '0);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (drop) begin
            overflow_d = 1'b1;
        end
        if (commit && (commit_size > pack_size_q)) begin
            pack_size_d = commit_size;
        end
    end

    // dl_q resets high so a window still open at reset release is not
    // mistaken for a fresh rising edge.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            dl_q        <= 1'b1;
            cpu_ack_q   <= 1'b0;
            loaded_q    <= 1'b0;
            overflow_q  <= 1'b0;
            pack_size_q <= '0;
        end else begin
            state_q     <= state_d;
            dl_q        <= ioctl_download;
            cpu_ack_q   <= cpu_rd_req;
            loaded_q    <= loaded_d;
            overflow_q  <= overflow_d;
            pack_size_q <= pack_size_d;
        end
    end

    assign ioctl_wait = buf_valid;
    assign cpu_ack    = cpu_ack_q;
    assign mem_we     = commit;
    assign mem_addr   = commit ? buf_addr : cpu_addr;
    assign mem_din    = buf_data;
    assign loaded     = loaded_q;
    assign pack_size  = pack_size_q;
    assign overflow   = overflow_q;
    assign busy       = in_xfer;

endmodule

// File: tb/tb_rom_pack_loader.sv
// Directed bench for rom_pack_loader: normal load, CPU priority and
// back-pressure, dropped bytes, out-of-range address, foreign index,
// empty load and reset in the middle of a download.
module tb_rom_pack_loader;

    localparam int AW = 15;

    logic          clk_sys = 1'b0;
    logic          reset_n;
    logic          ioctl_download;
    logic [7:0]    ioctl_index;
    logic          ioctl_wr;
    logic [24:0]   ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic          ioctl_wait;
    logic          cpu_rd_req;
    logic [AW-1:0] cpu_addr;
    logic          cpu_ack;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_din;
    logic          mem_we;
    logic          loaded;
    logic [AW:0]   pack_size;
    logic          overflow;
    logic          busy;

    int n_assert = 0;
    int n_fail   = 0;

    rom_pack_loader #(.INDEX(1), .AW(AW)) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .cpu_rd_req     (cpu_rd_req),
        .cpu_addr       (cpu_addr),
        .cpu_ack        (cpu_ack),
        .mem_addr       (mem_addr),
        .mem_din        (mem_din),
        .mem_we         (mem_we),
        .loaded         (loaded),
        .pack_size      (pack_size),
        .overflow       (overflow),
        .busy           (busy)
    );

    always #27 clk_sys = ~clk_sys;

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"},  32'(busy),       0);
        chk({tag, "_wait"},  32'(ioctl_wait), 0);
        chk({tag, "_we"},    32'(mem_we),     0);
        chk({tag, "_ack"},   32'(cpu_ack),    0);
        chk({tag, "_ld"},    32'(loaded),     0);
        chk({tag, "_ovf"},   32'(overflow),   0);
        chk({tag, "_size"},  32'(pack_size),  0);
    endtask

    initial begin
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        cpu_rd_req     = 1'b0;
        cpu_addr       = '0;
        repeat (3) step();
        #1;
        chk_reset_vals("rst");
        step();
        reset_n = 1'b1;

        // Normal 4-byte load, back-to-back strobes.
        step(); ioctl_download = 1'b1; ioctl_index = 8'd1; #1;
        chk("idle_busy", 32'(busy), 0);
        for (int i = 0; i < 4; i++) begin
            step();
            ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = 8'(8'hAA + 8'h11 * i); #1;
            chk("l1_we", 32'(mem_we), (i != 0) ? 1 : 0);
            chk("l1_busy", 32'(busy), 1);
            if (i != 0) begin
                chk("l1_addr", 32'(mem_addr), i - 1);
                chk("l1_din", 32'(mem_din), 32'(8'(8'hAA + 8'h11 * (i - 1))));
            end
        end
        step(); ioctl_wr = 1'b0; ioctl_download = 1'b0; #1;
        chk("l1_we3", 32'(mem_we), 1);
        chk("l1_addr3", 32'(mem_addr), 3);
        chk("l1_din3", 32'(mem_din), 32'hDD);
        step(); #1;
        chk("l1_flush_busy", 32'(busy), 1);
        chk("l1_flush_we", 32'(mem_we), 0);
        step(); #1;
        chk("l1_done_busy", 32'(busy), 0);
        chk("l1_loaded", 32'(loaded), 1);
        chk("l1_size", 32'(pack_size), 4);
        chk("l1_ovf", 32'(overflow), 0);

        // CPU read held 3 cycles while a byte is buffered.
        step(); ioctl_download = 1'b1; #1;
        step(); ioctl_wr = 1'b1; ioctl_addr = 25'h10; ioctl_dout = 8'h55; #1;
        chk("l2_clr_ld", 32'(loaded), 0);
        chk("l2_clr_size", 32'(pack_size), 0);
        step(); ioctl_wr = 1'b0; cpu_rd_req = 1'b1; cpu_addr = 15'h1234; #1;
        chk("l2_wait0", 32'(ioctl_wait), 1);
        chk("l2_we0", 32'(mem_we), 0);
        chk("l2_maddr0", 32'(mem_addr), 32'h1234);
        chk("l2_ack0", 32'(cpu_ack), 0);
        for (int i = 0; i < 2; i++) begin
            step(); #1;
            chk("l2_wait", 32'(ioctl_wait), 1);
            chk("l2_we", 32'(mem_we), 0);
            chk("l2_ack", 32'(cpu_ack), 1);
        end
        step(); cpu_rd_req = 1'b0; #1;
        chk("l2_ack3", 32'(cpu_ack), 1);
        chk("l2_we_commit", 32'(mem_we), 1);
        chk("l2_addr_commit", 32'(mem_addr), 32'h10);
        chk("l2_din_commit", 32'(mem_din), 32'h55);
        step(); #1;
        chk("l2_ack_end", 32'(cpu_ack), 0);
        chk("l2_we_end", 32'(mem_we), 0);
        chk("l2_wait_end", 32'(ioctl_wait), 0);
        chk("l2_size", 32'(pack_size), 32'h11);

        // Second strobe while full and CPU reading: dropped.
        step(); ioctl_wr = 1'b1; ioctl_addr = 25'h20; ioctl_dout = 8'h66; cpu_rd_req = 1'b1; #1;
        chk("l2_drop_wait0", 32'(ioctl_wait), 0);
        step(); ioctl_addr = 25'h21; ioctl_dout = 8'h77; #1;
        chk("l2_drop_wait1", 32'(ioctl_wait), 1);
        chk("l2_drop_ovf0", 32'(overflow), 0);
        step(); ioctl_wr = 1'b0; #1;
        chk("l2_drop_ovf1", 32'(overflow), 1);
        chk("l2_drop_we", 32'(mem_we), 0);
        step(); cpu_rd_req = 1'b0; #1;
        chk("l2_first_we", 32'(mem_we), 1);
        chk("l2_first_addr", 32'(mem_addr), 32'h20);
        chk("l2_first_din", 32'(mem_din), 32'h66);
        step(); #1;
        chk("l2_second_we", 32'(mem_we), 0);
        chk("l2_second_wait", 32'(ioctl_wait), 0);
        chk("l2_size2", 32'(pack_size), 32'h21);
        step(); ioctl_download = 1'b0;
        step(); step(); #1;
        chk("l2_loaded", 32'(loaded), 1);
        chk("l2_ovf_done", 32'(overflow), 1);
        chk("l2_size_done", 32'(pack_size), 32'h21);
        chk("l2_busy_done", 32'(busy), 0);

        // Out-of-range address, then the top valid address.
        step(); ioctl_download = 1'b1; #1;
        step(); ioctl_wr = 1'b1; ioctl_addr = 25'h8000; ioctl_dout = 8'h99; #1;
        chk("l3_ovf_clr", 32'(overflow), 0);
        chk("l3_size_clr", 32'(pack_size), 0);
        step(); ioctl_wr = 1'b0; #1;
        chk("l3_oob_we", 32'(mem_we), 0);
        chk("l3_oob_wait", 32'(ioctl_wait), 0);
        chk("l3_oob_ovf", 32'(overflow), 1);
        chk("l3_oob_size", 32'(pack_size), 0);
        step(); ioctl_wr = 1'b1; ioctl_addr = 25'h7FFF; ioctl_dout = 8'h5A; #1;
        step(); ioctl_wr = 1'b0; #1;
        chk("l3_top_we", 32'(mem_we), 1);
        chk("l3_top_addr", 32'(mem_addr), 32'h7FFF);
        step(); ioctl_download = 1'b0; #1;
        chk("l3_top_size", 32'(pack_size), 32'h8000);
        step(); step(); #1;
        chk("l3_loaded", 32'(loaded), 1);
        chk("l3_size_done", 32'(pack_size), 32'h8000);

        // Foreign index: ignored entirely.
        step(); ioctl_download = 1'b1; ioctl_index = 8'd2; #1;
        for (int i = 0; i < 16; i++) begin
            step(); ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = 8'(i); #1;
            chk("l4_we", 32'(mem_we), 0);
            chk("l4_busy", 32'(busy), 0);
        end
        step(); ioctl_wr = 1'b0; ioctl_download = 1'b0;
        step(); step(); #1;
        chk("l4_we_end", 32'(mem_we), 0);
        chk("l4_loaded", 32'(loaded), 1);
        chk("l4_size", 32'(pack_size), 32'h8000);
        chk("l4_busy_end", 32'(busy), 0);

        // Empty load leaves loaded low.
        step(); ioctl_download = 1'b1; ioctl_index = 8'd1;
        step(); ioctl_download = 1'b0;
        step(); step(); #1;
        chk("l5_loaded", 32'(loaded), 0);
        chk("l5_size", 32'(pack_size), 0);
        chk("l5_busy", 32'(busy), 0);

        // Reset after 2 of 8 bytes, then a full reload.
        step(); ioctl_download = 1'b1;
        step(); ioctl_wr = 1'b1; ioctl_addr = 25'd0; ioctl_dout = 8'h01;
        step(); ioctl_addr = 25'd1; ioctl_dout = 8'h02;
        step(); ioctl_wr = 1'b0; reset_n = 1'b0; #1;
        chk_reset_vals("midrst");
        step(); step(); reset_n = 1'b1;
        step(); ioctl_wr = 1'b1; ioctl_addr = 25'd5; #1;
        chk("l6_no_edge_busy", 32'(busy), 0);
        step(); ioctl_wr = 1'b0; #1;
        chk("l6_no_edge_we", 32'(mem_we), 0);
        chk("l6_no_edge_wait", 32'(ioctl_wait), 0);
        ioctl_download = 1'b0;
        step(); step(); ioctl_download = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(); ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = 8'(i * 3); #1;
            chk("l6_we", 32'(mem_we), (i != 0) ? 1 : 0);
        end
        step(); ioctl_wr = 1'b0; ioctl_download = 1'b0;
        step(); step(); #1;
        chk("l6_size", 32'(pack_size), 8);
        chk("l6_loaded", 32'(loaded), 1);
        chk("l6_busy", 32'(busy), 0);
        chk("l6_ovf", 32'(overflow), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_pack_loader.md
ROM_PACK_LOADER -- requirements
Module: rom_pack_loader

Interface
REQ-001 Parameter: INDEX, default 1, ioctl_index value that selects the ROM pack ("Load to ROM Pack").
REQ-002 Parameter: AW, default 15, ROM pack address width (32 KB).
REQ-003 clk_sys  in  1  system clock (18.432 MHz); sole clock.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 ioctl_download  in  1  download window active.
REQ-006 ioctl_index  in  8  download target index.
REQ-007 ioctl_wr  in  1  one-cycle byte strobe.
REQ-008 ioctl_addr  in  25  byte address.
REQ-009 ioctl_dout  in  8  byte data.
REQ-010 ioctl_wait  out  1  back-pressure to the download source.
REQ-011 cpu_rd_req  in  1  core read request for the ROM pack, level.
REQ-012 cpu_addr  in  AW  core read address.
REQ-013 cpu_ack  out  1  one-cycle read acknowledge; memory data valid.
REQ-014 mem_addr  out  AW  pack RAM address.
REQ-015 mem_din  out  8  pack RAM write data.
REQ-016 mem_we  out  1  pack RAM write enable, one cycle per byte.
REQ-017 loaded  out  1  pack image complete and valid.
REQ-018 pack_size  out  AW+1  highest written address + 1.
REQ-019 overflow  out  1  at least one byte dropped in the current load.
REQ-020 busy  out  1  state is not IDLE or DONE.

Function
REQ-021 Four states: IDLE, RECV, FLUSH, DONE.
REQ-022 IDLE/DONE -> RECV on rising edge of ioctl_download with ioctl_index==INDEX; this cycle clears loaded, overflow and pack_size.
REQ-023 Download windows with any other index are ignored; state and outputs are unchanged.
REQ-024 RECV: ioctl_wr captures {ioctl_addr, ioctl_dout} into a one-entry buffer.
REQ-025 A buffered byte commits (mem_we=1, mem_addr/mem_din = buffered values) on the first cycle with cpu_rd_req=0; minimum latency ioctl_wr -> mem_we is 1 cycle.
REQ-026 cpu_rd_req has priority: while high, mem_addr=cpu_addr combinationally and mem_we=0; cpu_ack pulses the following cycle.
REQ-027 ioctl_wait = buffer full; ioctl_wr with the buffer full and not committing this cycle drops the byte and sets overflow.
REQ-028 A byte committing and a new ioctl_wr in the same cycle: the commit and the capture both occur; no loss.
REQ-029 Byte with ioctl_addr >= 2^AW: not buffered, not written, sets overflow.
REQ-030 On each commit pack_size = max(pack_size, addr+1); maximum value is 2^AW.
REQ-031 RECV -> FLUSH on falling edge of ioctl_download; FLUSH -> DONE once the buffer is empty.
REQ-032 DONE: loaded=1 when pack_size!=0, else loaded=0.
REQ-033 Outside RECV/FLUSH, mem_we=0 and mem_addr=cpu_addr.
REQ-034 A new matching download during FLUSH is accepted only after DONE is reached; if the rising edge is missed, the load is ignored.

Reset
REQ-035 While reset_n=0: state=IDLE, buffer empty, ioctl_wait=0, mem_we=0, cpu_ack=0, loaded=0, overflow=0, pack_size=0, busy=0.
REQ-036 Reset mid-download discards the partial image; after release, a load requires a fresh rising edge of ioctl_download.

Structure
REQ-037 Shared package pmd85_pkg holds the loader state enum, IOCTL_IDX_ROMPACK=1 and ROMPACK_AW=15.
REQ-038 The one-entry buffer is a separate sub-module, ioctl_skid_buf, containing valid, addr and data.

Verification
REQ-039 Index 1, 4 bytes at 0..3 (0xAA..0xDD), no CPU reads -> four mem_we pulses, each 1 cycle after its ioctl_wr; after the window falls, loaded=1 and pack_size=4.
REQ-040 cpu_rd_req held 3 cycles during a byte at addr 0x10 -> ioctl_wait=1 for those cycles; mem_we deferred to the cycle after cpu_rd_req falls; 3 cpu_ack pulses.
REQ-041 Byte at ioctl_addr=0x8000 (AW=15) -> no mem_we; overflow=1; pack_size unchanged.
REQ-042 Download with index 2 of 16 bytes -> no mem_we; loaded, pack_size and busy unchanged.
REQ-043 reset_n pulsed low after 2 of 8 bytes -> all outputs at reset values; a subsequent full load at 0..7 gives pack_size=8 and loaded=1.
REQ-044 Second ioctl_wr issued while ioctl_wait=1 and cpu_rd_req=1 -> second byte dropped; overflow=1; first byte written after cpu_rd_req falls.
